// File: rtl/cic_interp_pkg.sv
// rtl/cic_interp_pkg.sv - shared CIC sizing helpers and default rate/delay/stage counts
package cic_interp_pkg;

    localparam int R_DEFAULT = 10;
    localparam int D_DEFAULT = 5;
    localparam int N_DEFAULT = 3;

    function automatic int cic_clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Bit growth of an N-stage CIC is N*log2(R*D) on top of the input width.
    function automatic int cic_acc_width(input int in_w, input int n, input int r, input int d);
        return in_w + n * cic_clog2(r * d);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// rtl/cic_integrator_stage.sv - registered wrap-around accumulator with enable
module cic_integrator_stage #(
    parameter int W = 42
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - N-stage CIC interpolator: comb chain, zero-stuff upsampler, integrator chain
module cic_interp
    import cic_interp_pkg::*;
#(
    parameter int R            = R_DEFAULT,
    parameter int D            = D_DEFAULT,
    parameter int N            = N_DEFAULT,
    parameter int INPUT_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 42
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    input  logic                           din_valid,
    output logic                           din_ready,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           dout_valid
);

    localparam int ACC_W = cic_acc_width(INPUT_WIDTH, N, R, D);
    localparam int PH_W  = cic_clog2(R);

    logic [PH_W-1:0]         phase_q, phase_d;
    logic                    accept;
    logic                    adv;
    logic [N:0][ACC_W-1:0]   comb_c;
    logic [ACC_W-1:0]        comb_q, comb_d;
    logic [ACC_W-1:0]        upsmp_q, upsmp_d;
    logic [N:0][ACC_W-1:0]   integ_c;
    logic [OUTPUT_WIDTH-1:0] dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;

    assign din_ready = (phase_q == '0);
    assign accept    = din_valid & din_ready;
    // Only an underrun at phase 0 stalls; every other phase advances unconditionally.
    assign adv       = (phase_q != '0) | accept;

    assign comb_c[0] = ACC_W'(din);

    for (genvar k = 0; k < N; k++) begin : g_comb
        logic [ACC_W-1:0] dly_q [D];
        logic [ACC_W-1:0] dly_d [D];

        always_comb begin
            dly_d = dly_q;
            if (accept) begin
                dly_d[0] = comb_c[k];
                for (int j = 1; j < D; j++) begin
                    dly_d[j] = dly_q[j-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < D; j++) begin
                    dly_q[j] <= '0;
                end
            end else begin
                dly_q <= dly_d;
            end
        end

        assign comb_c[k+1] = comb_c[k] - dly_q[D-1];
    end

    assign integ_c[0] = upsmp_q;

    for (genvar k = 0; k < N; k++) begin : g_integ
        cic_integrator_stage #(
            .W (ACC_W)
        ) u_integ (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .din   (integ_c[k]),
            .acc   (integ_c[k+1])
        );
    end

    always_comb begin
        phase_d      = phase_q;
        comb_d       = comb_q;
        upsmp_d      = upsmp_q;
        dout_d       = dout_q;
        dout_valid_d = adv;
        if (accept) begin
            comb_d = comb_c[N];
        end
        if (adv) begin
            phase_d = (phase_q == PH_W'(R - 1)) ? '0 : phase_q + 1'b1;
            upsmp_d = (phase_q == PH_W'(1)) ? comb_q : '0;
            dout_d  = integ_c[N][ACC_W-1 -: OUTPUT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            comb_q       <= '0;
            upsmp_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            comb_q       <= comb_d;
            upsmp_q      <= upsmp_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
